fsmcnt_seq: RTL
===============

Name: fsmcnt_seq

Overview:
- Parametrised successor to the fixed 4-digit round-robin display counter: up to 8 digits, programmable visit order, selectable base, count direction, auto/manual advance, pause and clear.
- A tick divider or a manual step pulse drives a slot-sequencing FSM. On each advance event the digit named by the current slot is incremented or decremented, then the slot moves on.
- Digit values drive 7-segment outputs through the existing hexdigit decoder. The block sits directly under the DE2-115 top level, between clk/switches/keys and HEX0..HEX7.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz (documentation and default derivation only).
- TICK_DIV, CLK_FREQ, clock cycles per auto tick; legal range 2..2^32-1.
- NDIG, 4, number of active digits; legal range 1..8.
- BASE, 16, digit modulus; legal values 2..16 (10 = decimal).
- ORDER, 24'o76541320, visit order; slot k's digit index is ORDER[3k+2:3k]. The default visits 0,2,3,1 for NDIG=4.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, 1 = run; 0 = freeze divider and ignore all advance events.
- manual, in, 1, 1 = advance on step rising edge; 0 = advance on tick.
- step, in, 1, manual advance request (synchronous level; rising edge detected internally).
- dir, in, 1, 0 = increment, 1 = decrement.
- clear, in, 1, synchronous clear of digits, slot and divider.
- hex, out, 56, 8 x 7-segment, active-low; digit i occupies hex[7i+6:7i].
- digits, out, 32, raw digit values; digit i occupies digits[4i+3:4i].
- slot, out, 3, current slot index.
- tick, out, 1, one-cycle auto-tick pulse (registered).

Behaviour:
- Reset (rst_n=0, async): cnt=0, tick=0, slot=0, step_q=0, all digits=0. Active hex digits show "0"; unused digits are blank.
- Divider:
  - When en=1: if cnt==TICK_DIV-1, then cnt<=0 and tick<=1; otherwise cnt<=cnt+1 and tick<=0.
  - When en=0: cnt holds and tick<=0.
  - tick pulses every TICK_DIV cycles, regardless of manual.
- Step edge: step_q<=step every cycle. step_rise = step & ~step_q. A held step counts once.
- Advance event: adv = en & ~clear & (manual ? step_rise : tick). A tick arriving while manual=1 is discarded. A step while manual=0 is ignored.
- FSM: state = slot, range 0..NDIG-1. On adv, slot <= (slot==NDIG-1) ? 0 : slot+1. No other transitions.
- Digit update on adv:
  - d = ORDER[3*slot+2 -: 3].
  - If d < NDIG: with dir=0, digit[d] <= (digit[d]==BASE-1) ? 0 : digit[d]+1. With dir=1, digit[d] <= (digit[d]==0) ? BASE-1 : digit[d]-1.
  - If d >= NDIG: no digit changes, but slot still advances (dead slot).
- Latency: the digit, slot and hex outputs change on the clock edge that samples adv, and are visible one cycle after tick is high or one cycle after the step rise is sampled.
- clear has priority over adv: cnt<=0, tick<=0, slot<=0, all digits<=0. step_q still updates.
- en=0 mid-sequence: all state holds. Resuming continues from the same cnt and slot.
- Changing dir or manual takes effect on the next adv. No state is reset.
- Digits with index >= NDIG: held at 0, digits field reads 0, hex field = 7'h7F.
- hex for i < NDIG is hexdigit(digit[i]), purely combinational from the digit registers.

Decomposition:
- Package fsmcnt_pkg:
  - MAX_DIG=8, SLOT_W=3, DIG_W=4, SEG_W=7.
  - SEG_BLANK=7'h7F.
  - function next_digit(val, dir, base) implementing the wrap rules.
- Sub-modules: reuse the existing hexdigit, one instance per digit in a generate loop. Blank via a mux when i >= NDIG. No new sub-module.

Test Plan (TICK_DIV=4, NDIG=4, BASE=16, default ORDER unless stated):
- Reset, en=1, manual=0, run 16 cycles -> tick high at cycles 4,8,12,16. After each tick, digits sequence is 0001, 0101, 1101, 1111 (digit3..digit0); slot ends at 0.
- Wrap: BASE=10, NDIG=1, ORDER slot0=0, 12 ticks -> digit0 goes 1..9,0,1,2. dir=1 from 0 -> 9 on the next tick.
- Manual: manual=1, step held high for 10 cycles, then low and high again -> exactly 2 advances. Ticks during this period cause no change. digits=0x0101, slot=2.
- Priority: clear=1 in the same cycle as tick -> digits=0, slot=0, cnt=0; next tick arrives 4 cycles after clear drops.
- Pause/dead slot: en=0 for 7 cycles mid-count -> cnt, slot and digits frozen, tick=0. NDIG=3 with default ORDER -> slot 2 (index 3) advances with no digit change. hex[27:21] and above = 7'h7F.
- Async reset asserted mid-cycle with nonzero digits -> all outputs at reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/fsmcnt_pkg.sv
// Shared sizes, slot encoding and digit wrap helper for the round-robin display counter.
package fsmcnt_pkg;

    localparam int MAX_DIG = 8;
    localparam int SLOT_W  = 3;
    localparam int DIG_W   = 4;
    localparam int SEG_W   = 7;

    // All segments off (active-low) for digits outside the active set.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Slot index of the sequencing FSM; only SLOT0..SLOT(NDIG-1) are ever reached.
    typedef enum logic [SLOT_W-1:0] {
        SLOT0, SLOT1, SLOT2, SLOT3, SLOT4, SLOT5, SLOT6, SLOT7
    } slot_e;

    // One step of a modulo-base digit: dir=0 counts up, dir=1 counts down, both wrap.
    function automatic logic [DIG_W-1:0] next_digit(input logic [DIG_W-1:0] val,
                                                    input logic             dir,
                                                    input logic [DIG_W:0]   base);
        logic [DIG_W-1:0] top;
        top = DIG_W'(base - 5'd1);
        if (!dir) begin
            next_digit = (val == top) ? '0 : val + 1'b1;
        end else begin
            next_digit = (val == '0) ? top : val - 1'b1;
        end
    endfunction

endpackage

// File: rtl/hexdigit.sv
// Hex value to active-low 7-segment pattern, segment order {g,f,e,d,c,b,a}.
module hexdigit (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pure lookup table; every input value maps to a pattern.
    always_comb begin
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/fsmcnt_seq.sv
// Round-robin multi-digit counter: a tick divider or manual step advances a slot FSM,
// each advance bumps the digit named by the current slot, digits drive 7-segment outputs.
module fsmcnt_seq
    import fsmcnt_pkg::*;
#(
    parameter int          CLK_FREQ = 50_000_000,
    parameter int unsigned TICK_DIV = CLK_FREQ,
    parameter int          NDIG     = 4,
    parameter int          BASE     = 16,
    parameter logic [23:0] ORDER    = 24'o76541320
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       manual,
    input  logic                       step,
    input  logic                       dir,
    input  logic                       clear,
    output logic [MAX_DIG*SEG_W-1:0]   hex,
    output logic [MAX_DIG*DIG_W-1:0]   digits,
    output logic [SLOT_W-1:0]          slot,
    output logic                       tick
);

    logic [31:0]      cnt;
    logic             step_q;
    logic             step_rise;
    logic             adv;
    slot_e            slot_q;
    slot_e            slot_n;
    logic [SLOT_W-1:0] cur_dig;
    logic [DIG_W-1:0] dig_q [MAX_DIG];

    assign step_rise = step & ~step_q;
    // A tick is discarded in manual mode and a step is ignored in auto mode.
    assign adv       = en & ~clear & (manual ? step_rise : tick);
    assign slot      = slot_q;

    // Free-running divider producing a registered one-cycle tick every TICK_DIV cycles.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == 32'(TICK_DIV - 1)) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 32'd1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Step history for rising-edge detection; keeps tracking through clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // Slot FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT0;
        end else if (clear) begin
            slot_q <= SLOT0;
        end else begin
            slot_q <= slot_n;
        end
    end

    // Next slot and the digit index the current slot points at.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        slot_n  = slot_q;
        cur_dig = ORDER[3*int'(slot_q) +: 3];
        if (adv) begin
            slot_n = (int'(slot_q) == NDIG - 1) ? SLOT0 : slot_e'(slot_q + 3'd1);
        end
    end

    // Digit registers: the slot's digit moves one step on each advance; dead slots change nothing.
    // NOTE: the digit array is small and must read 0 after reset, so it is reset like plain flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DIG; i++) dig_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < MAX_DIG; i++) dig_q[i] <= '0;
        end else if (adv && (int'(cur_dig) < NDIG)) begin
            dig_q[cur_dig] <= next_digit(dig_q[cur_dig], dir, 5'(BASE));
        end
    end

    // Per-digit decode; digits outside the active set read 0 and show blank.
    for (genvar i = 0; i < MAX_DIG; i++) begin : g_dig
        logic [SEG_W-1:0] seg;
        hexdigit u_hex (
            .digit (dig_q[i]),
            .seg   (seg)
        );
        assign hex[SEG_W*i +: SEG_W]    = (i < NDIG) ? seg : SEG_BLANK;
        assign digits[DIG_W*i +: DIG_W] = (i < NDIG) ? dig_q[i] : '0;
    end

endmodule
